// File: rtl/flux_sched_pkg.sv
// Shared types for the tagged-flux round-robin scheduler: FSM state encoding
// and the tag-width helper used to size flux indices.
package flux_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Tag/index width; a single flux still needs one bit to carry an index.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around first-eligible search: returns the first set bit of eligible
// at or after start, wrapping past N-1 back to 0.
module rr_pick
  import flux_sched_pkg::*;
#(
  parameter int N = 2,
  localparam int TW = tag_width(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [TW-1:0] start,
  output logic          hit,
  output logic [TW-1:0] index
);

  logic [TW-1:0] cand_idx [N];
  logic [N-1:0]  cand_ok;

  // Candidate gi is (start + gi) mod N; start < N so one subtraction suffices.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [TW:0] raw;
    assign raw          = {1'b0, start} + (TW+1)'(gi);
    assign cand_idx[gi] = (raw >= (TW+1)'(N)) ? TW'(raw - (TW+1)'(N)) : TW'(raw);
    assign cand_ok[gi]  = eligible[cand_idx[gi]];
  end

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_ok[k]) begin
        hit   = 1'b1;
        index = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin actor scheduler for FLUX tagged fluxes with a per-owner quantum.
// Optional statistics counters are enabled by defining FLUX_SCHED_STATS_EN.
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int QUANTUM    = 4,
  localparam int TW = tag_width(FLUX),
  localparam int CW = $clog2(QUANTUM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLUX-1:0]            empty,
  output logic [FLUX-1:0]            read,
  input  logic [TW+DATA_WIDTH-1:0]   dout,
  input  logic [FLUX-1:0]            full,
  output logic                       write,
  output logic [TW+DATA_WIDTH-1:0]   din,
  output logic [TW-1:0]              grant_tag,
  output logic                       busy
`ifdef FLUX_SCHED_STATS_EN
  ,
  output logic [FLUX-1:0][31:0]      tok_cnt,
  output logic [31:0]                stall_cnt
`endif
);

  state_t        state_reg, state_next;
  logic [TW-1:0] ptr_reg, ptr_next;
  logic [TW-1:0] owner_reg, owner_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [FLUX-1:0] eligible;
  logic            keep;
  logic [TW-1:0]   owner_inc;
  logic [TW-1:0]   pick_start;
  logic            pick_hit;
  logic [TW-1:0]   pick_idx;
  logic            xfer;
  logic            xfer_go;
  logic [TW-1:0]   xfer_tag;
  logic            unused_dout_tag;

  assign eligible  = ~empty & ~full;
  assign keep      = (state_reg == SERVE) && eligible[owner_reg] && (cnt_reg < CW'(QUANTUM));
  assign owner_inc = (owner_reg == TW'(FLUX - 1)) ? '0 : owner_reg + TW'(1);
  // Re-arbitration starts just past the owner so the owner is tested last.
  assign pick_start = (state_reg == SERVE) ? owner_inc : ptr_reg;

  rr_pick #(.N(FLUX)) u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .hit      (pick_hit),
    .index    (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    xfer       = 1'b0;
    xfer_tag   = owner_reg;
    if (keep) begin
      xfer     = 1'b1;
      cnt_next = cnt_reg + CW'(1);
    end else begin
      if (state_reg == SERVE) begin
        ptr_next = owner_inc;
      end
      if (pick_hit) begin
        xfer       = 1'b1;
        xfer_tag   = pick_idx;
        owner_next = pick_idx;
        cnt_next   = CW'(1);
        state_next = SERVE;
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end
  end

  // The transfer strobes are gated by rst_n so nothing moves while in reset.
  assign xfer_go = xfer & rst_n;
  assign write   = xfer_go;
  assign din     = {xfer_tag, dout[DATA_WIDTH-1:0]};
  assign unused_dout_tag = ^dout[TW+DATA_WIDTH-1:DATA_WIDTH];

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_read
    assign read[gi] = xfer_go && (xfer_tag == TW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      grant_tag <= '0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      grant_tag <= owner_next;
      busy      <= (state_next == SERVE);
    end
  end

`ifdef FLUX_SCHED_STATS_EN
  logic any_data;
  assign any_data = |(~empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (xfer && (xfer_tag == TW'(i))) begin
          tok_cnt[i] <= tok_cnt[i] + 32'd1;
        end
      end
      if (!xfer && any_data) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Bench for flux_rr_scheduler: a FLUX=2/QUANTUM=4 and a FLUX=3/QUANTUM=1 instance
// driven by FIFO models and checked every cycle against a behavioural arbiter.
module tb_flux_rr_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  empty2, full2, read2;
  logic [16:0] dout2, din2;
  logic        write2, busy2;
  logic [0:0]  grant2;
  logic [2:0]  empty3, full3, read3;
  logic [17:0] dout3, din3;
  logic        write3, busy3;
  logic [1:0]  grant3;
`ifdef FLUX_SCHED_STATS_EN
  logic [1:0][31:0] tok2;
  logic [2:0][31:0] tok3;
  logic [31:0]      stall2, stall3;
`endif

  flux_rr_scheduler #(.FLUX(2), .DATA_WIDTH(16), .QUANTUM(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .empty(empty2), .read(read2), .dout(dout2),
    .full(full2), .write(write2), .din(din2), .grant_tag(grant2), .busy(busy2)
`ifdef FLUX_SCHED_STATS_EN
    , .tok_cnt(tok2), .stall_cnt(stall2)
`endif
  );

  flux_rr_scheduler #(.FLUX(3), .DATA_WIDTH(16), .QUANTUM(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .empty(empty3), .read(read3), .dout(dout3),
    .full(full3), .write(write3), .din(din3), .grant_tag(grant3), .busy(busy3)
`ifdef FLUX_SCHED_STATS_EN
    , .tok_cnt(tok3), .stall_cnt(stall3)
`endif
  );

  // Source FIFO / sink model: token counts, full flags and current head payloads.
  int          avail [2][3];
  bit          fl    [2][3];
  logic [15:0] front [2][3];
  // Reference arbiter state: active owner, tokens in current run, search pointer.
  int m_act [2];
  int m_own [2];
  int m_run [2];
  int m_ptr [2];
  int m_tok [2][3];
  int m_stall [2];
  int total = 0;
  int bad = 0;
  int tlog2[$];
  int tlog3[$];

  always_comb begin
    dout2 = '0;
    dout3 = '0;
    for (int i = 0; i < 2; i++) begin
      empty2[i] = (avail[0][i] == 0);
      full2[i]  = fl[0][i];
      if (read2[i]) dout2 = {1'(i), front[0][i]};
    end
    for (int i = 0; i < 3; i++) begin
      empty3[i] = (avail[1][i] == 0);
      full3[i]  = fl[1][i];
      if (read3[i]) dout3 = {2'(i), front[1][i]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nflux(input int d);
    return (d != 0) ? 3 : 2;
  endfunction

  function automatic int quantum(input int d);
    return (d != 0) ? 1 : 4;
  endfunction

  function automatic bit elig(input int d, input int i);
    return (avail[d][i] > 0) && !fl[d][i];
  endfunction

  // Who moves a token this cycle, and what the arbiter looks like afterwards.
  task automatic decide(input int d, output int sel, output int nact, output int nown,
                        output int nrun, output int nptr);
    int n;
    int start;
    n = nflux(d);
    sel = -1;
    nact = m_act[d]; nown = m_own[d]; nrun = m_run[d]; nptr = m_ptr[d];
    if (!rst_n) begin
      nact = 0; nown = 0; nrun = 0; nptr = 0;
      return;
    end
    if (m_act[d] != 0 && elig(d, m_own[d]) && m_run[d] < quantum(d)) begin
      sel = m_own[d];
      nrun = m_run[d] + 1;
      return;
    end
    start = (m_act[d] != 0) ? (m_own[d] + 1) % n : m_ptr[d];
    if (m_act[d] != 0) nptr = start;
    for (int k = 0; k < n; k++) begin
      if (sel < 0 && elig(d, (start + k) % n)) sel = (start + k) % n;
    end
    if (sel >= 0) begin
      nact = 1; nown = sel; nrun = 1;
    end else begin
      nact = 0;
    end
  endtask

  task automatic check_outputs(input int d, input int sel);
    logic [31:0] exp_read;
    logic [31:0] exp_din;
    exp_read = (sel >= 0) ? (32'd1 << sel) : 32'd0;
    exp_din  = (sel >= 0) ? ((32'(sel) << 16) | 32'(front[d][(sel >= 0) ? sel : 0])) : 32'd0;
    if (d == 0) begin
      chk("d0_read", 32'(read2), exp_read);
      chk("d0_write", 32'(write2), 32'(sel >= 0));
      if (sel >= 0) chk("d0_din", 32'(din2), exp_din);
      chk("d0_busy", 32'(busy2), 32'(m_act[0]));
      chk("d0_grant", 32'(grant2), 32'(m_own[0]));
`ifdef FLUX_SCHED_STATS_EN
      chk("d0_stall", stall2, 32'(m_stall[0]));
      for (int i = 0; i < 2; i++) chk("d0_tok", tok2[i], 32'(m_tok[0][i]));
`endif
    end else begin
      chk("d1_read", 32'(read3), exp_read);
      chk("d1_write", 32'(write3), 32'(sel >= 0));
      if (sel >= 0) chk("d1_din", 32'(din3), exp_din);
      chk("d1_busy", 32'(busy3), 32'(m_act[1]));
      chk("d1_grant", 32'(grant3), 32'(m_own[1]));
`ifdef FLUX_SCHED_STATS_EN
      chk("d1_stall", stall3, 32'(m_stall[1]));
      for (int i = 0; i < 3; i++) chk("d1_tok", tok3[i], 32'(m_tok[1][i]));
`endif
    end
  endtask

  // One clock: check at the falling edge, update the models just after the rising edge.
  task automatic cycle();
    int sel [2];
    int na [2];
    int no [2];
    int nr [2];
    int np [2];
    bit any;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      decide(d, sel[d], na[d], no[d], nr[d], np[d]);
      check_outputs(d, sel[d]);
    end
    tlog2.push_back(sel[0]);
    tlog3.push_back(sel[1]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      any = 1'b0;
      for (int i = 0; i < nflux(d); i++) if (avail[d][i] > 0) any = 1'b1;
      if (!rst_n) begin
        m_stall[d] = 0;
        for (int i = 0; i < 3; i++) m_tok[d][i] = 0;
      end else if (sel[d] >= 0) begin
        avail[d][sel[d]]--;
        front[d][sel[d]] = 16'($urandom);
        m_tok[d][sel[d]]++;
      end else if (any) begin
        m_stall[d]++;
      end
      m_act[d] = na[d]; m_own[d] = no[d]; m_run[d] = nr[d]; m_ptr[d] = np[d];
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_own[d] = 0; m_run[d] = 0; m_ptr[d] = 0; m_stall[d] = 0;
      for (int i = 0; i < 3; i++) m_tok[d][i] = 0;
    end
  endtask

  int exp28 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int exp33 [4]  = '{0, 1, 2, 0};

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        avail[d][i] = 0; fl[d][i] = 1'b0; front[d][i] = 16'($urandom);
      end
    model_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_grant", 32'(grant2), 32'd0);
    repeat (3) cycle();

    // Two full fluxes on the quantum-4 instance, three on the quantum-1 instance.
    rst_n = 1'b1;
    avail[0][0] = 10; avail[0][1] = 10;
    avail[1][0] = 5;  avail[1][1] = 5; avail[1][2] = 5;
    tlog2.delete(); tlog3.delete();
    repeat (26) cycle();
    for (int i = 0; i < 10; i++) chk("seq_quantum4", 32'(tlog2[i]), 32'(exp28[i]));
    for (int i = 0; i < 20; i++) chk("seq_no_bubble", 32'(tlog2[i] >= 0), 32'd1);
    for (int i = 0; i < 4; i++) chk("seq_flux3_wrap", 32'(tlog3[i]), 32'(exp33[i]));

    // Flux 0 runs dry after two tokens: flux 1 follows with no bubble.
    avail[0][0] = 2; avail[0][1] = 5;
    tlog2.delete();
    repeat (12) cycle();
    chk("dry_t0", 32'(tlog2[0]), 32'd0);
    chk("dry_t1", 32'(tlog2[1]), 32'd0);
    chk("dry_t2", 32'(tlog2[2]), 32'd1);

    // Only flux 1 has data but its sink is full: nothing moves.
    avail[0][1] = 3; fl[0][1] = 1'b1;
    repeat (4) cycle();
    chk("full_busy", 32'(busy2), 32'd0);
    chk("full_write", 32'(write2), 32'd0);
    fl[0][1] = 1'b0;
    repeat (6) cycle();

    // Single active flux: nine back-to-back transfers across quantum boundaries.
    avail[0][1] = 9;
    tlog2.delete();
    repeat (12) cycle();
    for (int i = 0; i < 9; i++) chk("solo_flux1", 32'(tlog2[i]), 32'd1);
    chk("solo_end", 32'(tlog2[9]), 32'hFFFF_FFFF);

    // Reset in the middle of a quantum.
    avail[0][0] = 6; avail[0][1] = 6;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_read", 32'(read2), 32'd0);
    chk("midrst_write", 32'(write2), 32'd0);
    chk("midrst_busy", 32'(busy2), 32'd0);
    chk("midrst_grant", 32'(grant2), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    tlog2.delete();
    repeat (12) cycle();
    chk("postrst_first", 32'(tlog2[0]), 32'd0);
    chk("postrst_fifth", 32'(tlog2[4]), 32'd1);

    // Random traffic and back-pressure on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < nflux(d); i++) begin
          if (avail[d][i] == 0 && $urandom_range(0, 3) == 0) avail[d][i] = int'($urandom_range(1, 12));
          fl[d][i] = ($urandom_range(0, 4) == 0);
        end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
